// File: rtl/spectrum_peak_detect.sv
// Streaming magnitude estimator and per-block peak finder placed behind the sliding-DFT core.
// Three-stage pipeline: |re|,|im| -> alpha-max/beta-min magnitude -> running-max peak search.
module spectrum_peak_detect #(
  parameter int    N        = 4096,
  parameter int    IDW      = 32,
  parameter int    IMAG_EN  = 1,
  parameter int    OW       = (IMAG_EN != 0) ? 2*IDW : IDW,
  parameter string SPECTRUM = "full",
  parameter int    AW       = (SPECTRUM == "full") ? $clog2(N) : $clog2(N)-1,
  parameter int    SKIP_DC  = 1
) (
  input  logic           clk_i,
  input  logic           arst_n_i,
  input  logic [OW-1:0]  data_i,
  input  logic           sob_i,
  input  logic           eob_i,
  input  logic           valid_i,
  input  logic [IDW-1:0] threshold_i,
  output logic [IDW-1:0] mag_o,
  output logic           mag_valid_o,
  output logic           mag_sob_o,
  output logic           mag_eob_o,
  output logic [AW-1:0]  peak_idx_o,
  output logic [IDW-1:0] peak_mag_o,
  output logic           peak_valid_o,
  output logic           peak_above_o,
  output logic           frame_err_o
);

  localparam int            LAST     = (SPECTRUM == "full") ? N-1 : N/2-1;
  localparam logic [AW-1:0] LAST_IDX = AW'(LAST);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] IN_FRAME = 1'b1;

  // |-2^(IDW-1)| wraps back to 2^(IDW-1), which is the correct unsigned value.
  function automatic logic [IDW-1:0] abs_val(input logic [IDW-1:0] x);
    return x[IDW-1] ? -x : x;
  endfunction

  logic [IDW-1:0] re_w, im_w;
  assign re_w = data_i[IDW-1:0];

  if (IMAG_EN != 0) begin : g_cplx
    assign im_w = data_i[2*IDW-1:IDW];
  end else begin : g_real
    assign im_w = '0;
  end

  // ---------------------------------------------------------------------------
  // Framing FSM, evaluated on the input beat; its decisions travel with the beat.
  // ---------------------------------------------------------------------------
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] bin_q, bin_d, beat_bin;
  logic          beat_track, beat_start, beat_done, beat_err;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d    = state_q;
    bin_d      = bin_q;
    beat_bin   = bin_q;
    beat_track = 1'b0;
    beat_start = 1'b0;
    beat_done  = 1'b0;
    beat_err   = 1'b0;
    if (valid_i) begin
      if (sob_i) begin
        beat_start = 1'b1;
        beat_track = 1'b1;
        beat_bin   = '0;
        bin_d      = '0;
        beat_err   = (state_q == IN_FRAME) || eob_i;
        state_d    = eob_i ? IDLE : IN_FRAME;
      end else if (state_q == IDLE) begin
        beat_err = 1'b1;
      end else begin
        beat_bin   = bin_q + AW'(1);
        bin_d      = beat_bin;
        beat_track = 1'b1;
        if (eob_i) begin
          state_d = IDLE;
          if (beat_bin == LAST_IDX) beat_done = 1'b1;
          else                      beat_err  = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S1: absolute values and beat flags
  // ---------------------------------------------------------------------------
  logic [IDW-1:0] abs_re_q, abs_im_q;
  logic           s1_valid_q, s1_sob_q, s1_eob_q;
  logic           s1_track_q, s1_start_q, s1_done_q, s1_err_q;
  logic [AW-1:0]  s1_bin_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    // NOTE: state registers use non-blocking assignments so every stage sees pre-edge values.
    if (!arst_n_i) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      abs_re_q   <= '0;
      abs_im_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_sob_q   <= 1'b0;
      s1_eob_q   <= 1'b0;
      s1_track_q <= 1'b0;
      s1_start_q <= 1'b0;
      s1_done_q  <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_bin_q   <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      abs_re_q   <= abs_val(re_w);
      abs_im_q   <= abs_val(im_w);
      s1_valid_q <= valid_i;
      s1_sob_q   <= valid_i & sob_i;
      s1_eob_q   <= valid_i & eob_i;
      s1_track_q <= beat_track;
      s1_start_q <= beat_start;
      s1_done_q  <= beat_done;
      s1_err_q   <= beat_err;
      s1_bin_q   <= beat_bin;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: magnitude = max + min/2; bounded by 3*2^(IDW-2), so no saturation needed
  // ---------------------------------------------------------------------------
  logic [IDW-1:0] mag_d, mag_q;
  logic           mag_valid_q, mag_sob_q, mag_eob_q;
  logic           s2_track_q, s2_start_q, s2_done_q, s2_err_q;
  logic [AW-1:0]  s2_bin_q;

  always_comb begin
    if (abs_re_q >= abs_im_q) mag_d = abs_re_q + (abs_im_q >> 1);
    else                      mag_d = abs_im_q + (abs_re_q >> 1);
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      mag_q       <= '0;
      mag_valid_q <= 1'b0;
      mag_sob_q   <= 1'b0;
      mag_eob_q   <= 1'b0;
      s2_track_q  <= 1'b0;
      s2_start_q  <= 1'b0;
      s2_done_q   <= 1'b0;
      s2_err_q    <= 1'b0;
      s2_bin_q    <= '0;
    end else begin
      mag_q       <= mag_d;
      mag_valid_q <= s1_valid_q;
      mag_sob_q   <= s1_sob_q;
      mag_eob_q   <= s1_eob_q;
      s2_track_q  <= s1_track_q;
      s2_start_q  <= s1_start_q;
      s2_done_q   <= s1_done_q;
      s2_err_q    <= s1_err_q;
      s2_bin_q    <= s1_bin_q;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: running max; strict '>' keeps the lowest index on ties
  // ---------------------------------------------------------------------------
  logic [IDW-1:0] max_mag_q, max_mag_d;
  logic [AW-1:0]  max_idx_q, max_idx_d;
  logic [AW-1:0]  peak_idx_q;
  logic [IDW-1:0] peak_mag_q;
  logic           peak_valid_q, peak_above_q, frame_err_q;
  logic           s2_eligible;

  assign s2_eligible = s2_track_q && !((SKIP_DC != 0) && (s2_bin_q == '0));

  always_comb begin
    max_mag_d = s2_start_q ? '0 : max_mag_q;
    max_idx_d = s2_start_q ? '0 : max_idx_q;
    if (s2_eligible && (mag_q > max_mag_d)) begin
      max_mag_d = mag_q;
      max_idx_d = s2_bin_q;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      max_mag_q    <= '0;
      max_idx_q    <= '0;
      peak_idx_q   <= '0;
      peak_mag_q   <= '0;
      peak_valid_q <= 1'b0;
      peak_above_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      if (s2_track_q) begin
        max_mag_q <= max_mag_d;
        max_idx_q <= max_idx_d;
      end
      peak_valid_q <= s2_done_q;
      frame_err_q  <= s2_err_q;
      if (s2_done_q) begin
        peak_idx_q   <= max_idx_d;
        peak_mag_q   <= max_mag_d;
        peak_above_q <= (max_mag_d >= threshold_i);
      end
    end
  end

  assign mag_o        = mag_q;
  assign mag_valid_o  = mag_valid_q;
  assign mag_sob_o    = mag_sob_q;
  assign mag_eob_o    = mag_eob_q;
  assign peak_idx_o   = peak_idx_q;
  assign peak_mag_o   = peak_mag_q;
  assign peak_valid_o = peak_valid_q;
  assign peak_above_o = peak_above_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_spectrum_peak_detect.sv
// Scoreboard bench for spectrum_peak_detect (N=16, IDW=32, complex, full spectrum, DC skipped).
// Stimulus pushes expected beats/results with their due cycle; a negedge monitor pops and compares.
module tb_spectrum_peak_detect;

  logic        clk_i = 1'b0;
  logic        arst_n_i = 1'b1;
  logic [63:0] data_i = '0;
  logic        sob_i = 1'b0, eob_i = 1'b0, valid_i = 1'b0;
  logic [31:0] threshold_i = '0;
  logic [31:0] mag_o, peak_mag_o;
  logic        mag_valid_o, mag_sob_o, mag_eob_o;
  logic [3:0]  peak_idx_o;
  logic        peak_valid_o, peak_above_o, frame_err_o;

  spectrum_peak_detect #(
    .N(16), .IDW(32), .IMAG_EN(1), .SPECTRUM("full"), .SKIP_DC(1)
  ) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .data_i(data_i),
    .sob_i(sob_i), .eob_i(eob_i), .valid_i(valid_i), .threshold_i(threshold_i),
    .mag_o(mag_o), .mag_valid_o(mag_valid_o), .mag_sob_o(mag_sob_o), .mag_eob_o(mag_eob_o),
    .peak_idx_o(peak_idx_o), .peak_mag_o(peak_mag_o), .peak_valid_o(peak_valid_o),
    .peak_above_o(peak_above_o), .frame_err_o(frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { int cyc; logic [31:0] mag; logic sob; logic eob; } mag_exp_t;
  typedef struct { int cyc; logic [3:0] idx; logic [31:0] mag; logic above; } pk_exp_t;

  mag_exp_t mag_q[$];
  pk_exp_t  pk_q[$];
  int       err_q[$];

  int total = 0;
  int bad   = 0;

  logic [31:0] blk_re [16];
  logic [31:0] blk_im [16];
  logic [3:0]  pk_idx;
  logic [31:0] pk_mag;
  logic        pk_above;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] fmag(input logic [31:0] re, input logic [31:0] im);
    logic [31:0] a, b;
    a = re[31] ? 32'(-re) : re;
    b = im[31] ? 32'(-im) : im;
    return (a > b) ? a + (b >> 1) : b + (a >> 1);
  endfunction

  // Reference peak: bins 1..15, first strictly-greater wins.
  task automatic model_peak(output logic [3:0] idx, output logic [31:0] mag);
    idx = '0;
    mag = '0;
    for (int b = 1; b < 16; b++) begin
      if (fmag(blk_re[b], blk_im[b]) > mag) begin
        mag = fmag(blk_re[b], blk_im[b]);
        idx = 4'(b);
      end
    end
  endtask

  task automatic clear_blk();
    for (int b = 0; b < 16; b++) begin
      blk_re[b] = '0;
      blk_im[b] = '0;
    end
  endtask

  task automatic beat(input logic [31:0] re, input logic [31:0] im,
                      input logic sob, input logic eob, input logic err, input logic pk);
    mag_exp_t me;
    pk_exp_t  pe;
    @(posedge clk_i); #1;
    data_i  = {im, re};
    sob_i   = sob;
    eob_i   = eob;
    valid_i = 1'b1;
    me.cyc = cyc + 2; me.mag = fmag(re, im); me.sob = sob; me.eob = eob;
    mag_q.push_back(me);
    if (err) err_q.push_back(cyc + 3);
    if (pk) begin
      pe.cyc = cyc + 3; pe.idx = pk_idx; pe.mag = pk_mag; pe.above = pk_above;
      pk_q.push_back(pe);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      sob_i   = 1'b0;
      eob_i   = 1'b0;
    end
  endtask

  task automatic send_block(input int nb, input bit gaps, input bit err_first,
                            input bit err_last, input bit pk);
    for (int b = 0; b < nb; b++) begin
      if (gaps && b > 0)
        while ($urandom_range(0, 99) < 30) idle(1);
      beat(blk_re[b], blk_im[b], b == 0, b == nb-1,
           (b == 0 && err_first) || (b == nb-1 && err_last), (b == nb-1) && pk);
    end
  endtask

  // Monitor: every presented output must match the head of its queue, cycle included.
  mag_exp_t mon_me;
  pk_exp_t  mon_pe;
  int       mon_ec;
  always @(negedge clk_i) begin
    if (arst_n_i) begin
      if (mag_valid_o) begin
        if (mag_q.size() == 0) check("mag_unexpected", 128'(mag_valid_o), 128'(0));
        else begin
          mon_me = mag_q.pop_front();
          check("mag_beat", {32'(cyc), mag_o, mag_sob_o, mag_eob_o},
                {32'(mon_me.cyc), mon_me.mag, mon_me.sob, mon_me.eob});
        end
      end
      if (peak_valid_o) begin
        if (pk_q.size() == 0) check("peak_unexpected", 128'(peak_valid_o), 128'(0));
        else begin
          mon_pe = pk_q.pop_front();
          check("peak_result", {32'(cyc), peak_idx_o, peak_mag_o, peak_above_o},
                {32'(mon_pe.cyc), mon_pe.idx, mon_pe.mag, mon_pe.above});
        end
      end
      if (frame_err_o) begin
        if (err_q.size() == 0) check("frame_err_unexpected", 128'(frame_err_o), 128'(0));
        else begin
          mon_ec = err_q.pop_front();
          check("frame_err_cycle", 128'(cyc), 128'(mon_ec));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    clear_blk();
    #2 arst_n_i = 1'b0;
    #1 check("reset_outputs",
             {mag_o, mag_valid_o, mag_sob_o, mag_eob_o, peak_idx_o, peak_mag_o,
              peak_valid_o, peak_above_o, frame_err_o}, 128'(0));
    idle(3);
    arst_n_i = 1'b1;
    idle(2);

    // Single peak bin 5: |-100|=100, |40|=40 -> 100 + 20 = 120; threshold equality then +1.
    blk_re[5] = -32'sd100;
    blk_im[5] = 32'd40;
    threshold_i = 32'd120;
    pk_idx = 4'd5; pk_mag = 32'd120; pk_above = 1'b1;
    send_block(16, 0, 0, 0, 1);
    idle(4);
    threshold_i = 32'd121;
    pk_above = 1'b0;
    send_block(16, 0, 0, 0, 1);
    idle(4);

    // Tie at bins 3 and 9 (mag 64), DC=1000 ignored; then back-to-back extreme block.
    clear_blk();
    blk_re[0] = 32'd1000;
    blk_re[3] = 32'd64;
    blk_re[9] = 32'd64;
    threshold_i = 32'd64;
    pk_idx = 4'd3; pk_mag = 32'd64; pk_above = 1'b1;
    send_block(16, 0, 0, 0, 1);
    clear_blk();
    blk_re[2] = 32'h8000_0000;
    blk_im[2] = 32'h8000_0000;
    pk_idx = 4'd2; pk_mag = 32'hC000_0000; pk_above = 1'b1;
    send_block(16, 0, 0, 0, 1);
    idle(4);

    // Truncated block (eob at bin 10): error, no result, previous result held.
    clear_blk();
    blk_re[4] = 32'd500;
    send_block(11, 0, 0, 1, 0);
    idle(5);
    check("peak_held", {peak_idx_o, peak_mag_o, peak_above_o}, {4'd2, 32'hC000_0000, 1'b1});

    // Stray beat while idle.
    beat(32'd7, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);

    // Seven-beat partial block (bin 1 = 300) aborted by a sob; new block peaks at bin 12.
    clear_blk();
    blk_re[1] = 32'd300;
    for (int b = 0; b < 7; b++) beat(blk_re[b], blk_im[b], b == 0, 1'b0, 1'b0, 1'b0);
    clear_blk();
    blk_re[12] = 32'd10;
    blk_im[12] = -32'sd30;
    threshold_i = 32'd0;
    pk_idx = 4'd12; pk_mag = 32'd35; pk_above = 1'b1;
    send_block(16, 0, 1, 0, 1);
    idle(4);

    // Two random blocks with ~30% idle gaps, checked against the reference model.
    threshold_i = 32'h8000_0000;
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < 16; b++) begin
        blk_re[b] = $urandom();
        blk_im[b] = $urandom();
      end
      model_peak(pk_idx, pk_mag);
      pk_above = (pk_mag >= threshold_i);
      send_block(16, 1, 0, 0, 1);
    end
    idle(5);

    // Reset asserted mid-block: outputs clear immediately, pending work is abandoned.
    clear_blk();
    blk_re[3] = 32'd900;
    for (int b = 0; b < 8; b++) beat(blk_re[b], blk_im[b], b == 0, 1'b0, 1'b0, 1'b0);
    @(posedge clk_i); #1;
    arst_n_i = 1'b0;
    valid_i  = 1'b0;
    sob_i    = 1'b0;
    eob_i    = 1'b0;
    #1 check("reset_mid_block",
             {mag_o, mag_valid_o, mag_sob_o, mag_eob_o, peak_idx_o, peak_mag_o,
              peak_valid_o, peak_above_o, frame_err_o}, 128'(0));
    mag_q.delete();
    pk_q.delete();
    err_q.delete();
    idle(2);
    arst_n_i = 1'b1;
    clear_blk();
    blk_im[7] = 32'd77;
    threshold_i = 32'd100;
    pk_idx = 4'd7; pk_mag = 32'd77; pk_above = 1'b0;
    send_block(16, 0, 0, 0, 1);
    idle(8);

    check("mag_queue_drained", 128'(mag_q.size()), 128'(0));
    check("peak_queue_drained", 128'(pk_q.size()), 128'(0));
    check("err_queue_drained", 128'(err_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spectrum_peak_detect.md
Name: spectrum_peak_detect

Overview:
- Streaming consumer placed directly downstream of the sliding-DFT core.
- Takes its per-sample frequency-domain block (sob/eob/valid framed, packed {im, re}) and computes an approximate magnitude per bin, forwarded as a stream.
- Tracks the strongest bin across each block and reports peak bin index and magnitude once per block, with a threshold flag.
- Checks block framing and flags protocol errors.

Parameters:
- N, 4096, transform size.
- IDW, 32, signed width of each re/im component.
- IMAG_EN, 1, 1: data_i = {im, re}; 0: data_i = re only.
- OW, IMAG_EN ? 2*IDW : IDW, input data width.
- SPECTRUM, "full", "full" or "half"; sets expected bins per block.
- AW, SPECTRUM=="full" ? $clog2(N) : $clog2(N)-1, bin index width.
- SKIP_DC, 1, 1: bin 0 excluded from peak search (still streamed).

Ports:
- clk_i  in  1  clock
- arst_n_i  in  1  asynchronous active-low reset
- data_i  in  OW  bin value; re = data_i[IDW-1:0], im = data_i[2*IDW-1:IDW]
- sob_i  in  1  first bin of block, qualified by valid_i
- eob_i  in  1  last bin of block, qualified by valid_i
- valid_i  in  1  beat valid; gaps allowed inside a block
- threshold_i  in  IDW  unsigned peak threshold, sampled when the result is produced
- mag_o  out  IDW  unsigned per-bin magnitude
- mag_valid_o, mag_sob_o, mag_eob_o  out  1 each  magnitude stream framing
- peak_idx_o  out  AW  bin index of block maximum
- peak_mag_o  out  IDW  magnitude of block maximum
- peak_valid_o  out  1  one-cycle pulse when a new result is available
- peak_above_o  out  1  peak_mag_o >= threshold_i
- frame_err_o  out  1  one-cycle pulse on a framing violation

Behaviour:
- Reset: async assert clears all outputs, state, counters and the running max to 0; state = IDLE. Deassertion is used synchronously.
- Magnitude is computed as max(|re|,|im|) + (min(|re|,|im|) >> 1).
  - |x| is unsigned IDW bits; |-2^(IDW-1)| = 2^(IDW-1) fits.
  - The sum is at most 3*2^(IDW-2), so it fits IDW bits with no saturation.
  - When IMAG_EN=0, mag = |re|.
- Pipeline:
  - S1 registers abs values and flags.
  - S2 registers the magnitude.
  - mag_* outputs equal S2, so latency from input beat to mag_valid_o is 2 cycles.
  - The mag stream follows valid_i beat-for-beat, including framing errors; it is not filtered.
- FSM, evaluated on valid_i beats only:
  - IDLE: a sob_i beat moves to IN_FRAME with bin counter = 0. A non-sob beat is dropped for the peak search and pulses frame_err_o.
  - IN_FRAME: each beat increments the bin counter (AW bits).
  - A sob_i beat while IN_FRAME pulses frame_err_o, discards the partial block, and restarts with bin = 0 on this beat.
  - An eob_i beat while IN_FRAME returns to IDLE. If the counter equals LAST = (SPECTRUM=="full" ? N-1 : N/2-1), a result is produced; otherwise frame_err_o pulses and no result is produced.
  - sob_i and eob_i on the same beat: frame_err_o pulses; the beat opens a new block (sob priority), then returns to IDLE with no result.
- Peak search, done in S3 on the S2 magnitude:
  - The running max is reset at the sob beat.
  - Update only on a strictly greater magnitude, so ties keep the lowest index.
  - With SKIP_DC=1, bin 0 never updates the max. If every bin is skipped or zero, the result is idx 0, mag 0.
- Result timing:
  - For an eob beat at cycle t, peak_valid_o pulses at t+3.
  - peak_idx_o, peak_mag_o and peak_above_o update on that same cycle and then hold until the next result.
- A result pulse and a frame_err_o pulse can coincide with a sob of the next block. Back-to-back blocks (eob then sob on the next cycle) must work with no lost beats.
- frame_err_o is a pulse, never sticky. It is asserted 3 cycles after the offending beat.

Test Plan:
- IMAG_EN=1, N=16, full, SKIP_DC=1. One block with all bins (re=0, im=0) except bin 5 = (re=-100, im=40) -> mag(bin 5) = 120 at a 2-cycle latency; peak_valid_o pulses once at eob+3 with idx 5, mag 120; threshold_i = 120 -> peak_above_o = 1, threshold_i = 121 -> 0.
- Bins 3 and 9 both (re=64, im=0), remainder 0 -> idx 3, mag 64 (tie keeps the lowest index); SKIP_DC=1 with bin 0 = 1000 -> bin 0 ignored.
- Extreme value: re = im = -2^31 (IDW=32) -> mag = 0xC000_0000 with no wrap.
- Block truncated (eob at bin 10) -> frame_err_o pulse, no peak_valid_o, previous result held. Stray valid beat in IDLE -> frame_err_o. sob at bin 7 mid-block -> frame_err_o, and the new block completes normally with a correct peak.
- Two back-to-back blocks with random valid_i gaps (30% idle) -> two results matching the reference model; mag stream matches beat-for-beat.
- arst_n_i asserted mid-block -> all outputs 0 immediately; after release, a full block yields a correct result with no frame_err_o.
